// File: rtl/uart_tx_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : uart_tx_fifo
// Purpose  : Buffered 8N1 UART transmitter with an internal bit-period
//            divider. A 2**ADDR_W entry FIFO decouples the producer from the
//            line rate, and queued bytes go out back-to-back with no idle gap.
// Options  : UART_TX_PARITY_EN - when defined, an even-parity bit is sent
//            between the last data bit and the stop bit (frame = 11*DIV clks).
//            When undefined the frame is plain 8N1 (frame = 10*DIV clks).
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
    parameter int DIV    = 8,   // clk cycles per bit, must be >= 2
    parameter int ADDR_W = 2    // FIFO address width, depth = 2**ADDR_W
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr,
    input  logic [7:0] din,
    output logic       full,
    output logic       empty,
    output logic       busy,
    output logic       done,
    output logic       out
);

    // ------------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------------
    localparam int DEPTH = 2 ** ADDR_W;
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [DIV_W-1:0]  c_div_last = DIV_W'(DIV - 1);
    localparam logic [DIV_W-1:0]  c_div_one  = DIV_W'(1);
    localparam logic [ADDR_W:0]   c_depth    = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   c_cnt_one  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] c_ptr_one  = ADDR_W'(1);

    // ------------------------------------------------------------------------
    // Line state machine encoding
    // ------------------------------------------------------------------------
`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;
`endif

    // ------------------------------------------------------------------------
    // FIFO state
    // ------------------------------------------------------------------------
    logic [7:0]        r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic              r_full;
    logic              r_empty;

    // ------------------------------------------------------------------------
    // Transmitter state
    // ------------------------------------------------------------------------
    state_t            r_state;
    logic [DIV_W-1:0]  r_div;
    logic [2:0]        r_bitcnt;
    logic [7:0]        r_shreg;
    logic              r_out;
    logic              r_busy;
    logic              r_done;
`ifdef UART_TX_PARITY_EN
    logic              r_parity;
`endif

    // ------------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------------
    logic              w_push;
    logic              w_bit_end;
    logic              w_load;
    logic [7:0]        w_head;
    logic [ADDR_W:0]   w_count_next;

    // full is the registered flag, so a write presented while full is dropped
    // even if the same edge frees a slot through a pop.
    assign w_push    = wr & ~r_full;
    assign w_bit_end = (r_div == c_div_last);
    assign w_head    = r_mem[r_rd_ptr];

    // A byte is taken from the FIFO when the line is idle, or at the very end
    // of a stop bit so the next start bit follows without a gap.
    assign w_load = ~r_empty &
                    ((r_state == ST_IDLE) | ((r_state == ST_STOP) & w_bit_end));

    // Next occupancy: simultaneous push and pop leaves the count unchanged.
    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_load})
            2'b10:   w_count_next = r_count + c_cnt_one;
            2'b01:   w_count_next = r_count - c_cnt_one;
            default: w_count_next = r_count;
        endcase
    end

    // FIFO storage: data array is not reset, only the pointers are.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // FIFO pointers, occupancy and registered full/empty flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_load) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            r_count <= w_count_next;
            r_full  <= (w_count_next == c_depth);
            r_empty <= (w_count_next == '0);
        end
    end

`ifdef UART_TX_PARITY_EN
    // Even parity of the byte being framed, captured when it leaves the FIFO.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_parity <= 1'b0;
        end else if (w_load) begin
            r_parity <= ^w_head;
        end
    end
`endif

    // Line FSM: the serial output, busy and done are all registered here and
    // change on the same edge as the state they belong to.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_div    <= '0;
            r_bitcnt <= '0;
            r_shreg  <= '0;
            r_out    <= 1'b1;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;

            // Bit-period divider runs in every state except IDLE.
            if (r_state != ST_IDLE) begin
                r_div <= w_bit_end ? '0 : (r_div + c_div_one);
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_load) begin
                        r_shreg <= w_head;
                        r_div   <= '0;
                        r_state <= ST_START;
                        r_out   <= 1'b0;
                        r_busy  <= 1'b1;
                    end
                end

                ST_START: begin
                    if (w_bit_end) begin
                        r_state  <= ST_DATA;
                        r_bitcnt <= '0;
                        r_out    <= r_shreg[0];
                    end
                end

                ST_DATA: begin
                    if (w_bit_end) begin
                        r_shreg  <= {1'b0, r_shreg[7:1]};
                        r_bitcnt <= r_bitcnt + 3'd1;
                        if (r_bitcnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            r_state <= ST_PARITY;
                            r_out   <= r_parity;
`else
                            r_state <= ST_STOP;
                            r_out   <= 1'b1;
`endif
                        end else begin
                            // Next LSB is the one about to shift into bit 0.
                            r_out <= r_shreg[1];
                        end
                    end
                end

`ifdef UART_TX_PARITY_EN
                ST_PARITY: begin
                    if (w_bit_end) begin
                        r_state <= ST_STOP;
                        r_out   <= 1'b1;
                    end
                end
`endif

                ST_STOP: begin
                    if (w_bit_end) begin
                        r_done <= 1'b1;
                        if (w_load) begin
                            r_shreg <= w_head;
                            r_state <= ST_START;
                            r_out   <= 1'b0;
                        end else begin
                            r_state <= ST_IDLE;
                            r_out   <= 1'b1;
                            r_busy  <= 1'b0;
                        end
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_out   <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign full  = r_full;
    assign empty = r_empty;
    assign busy  = r_busy;
    assign done  = r_done;
    assign out   = r_out;

endmodule
`default_nettype wire

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Buffered UART transmitter on a single system clock with an internal bit-period divider. It is the transmit-side counterpart to uart_rx: it serialises bytes queued by a producer into 8N1 frames, so a uart_rx_filter/uart_rx pair on the same clk can receive them. A small FIFO decouples the producer from the line rate. Back-to-back frames are sent with no idle gap.

Parameters:
DIV, 8, clk cycles per bit; must be >= 2. The default of 8 matches the uart_rx sampling rate.
ADDR_W, 2, FIFO address width; FIFO depth = 2**ADDR_W entries.

Ports:
clk  input  1  system clock; all state updates on posedge.
reset  input  1  asynchronous, active-high reset.
wr  input  1  write strobe; byte accepted on a posedge where wr=1 and full=0.
din  input  8  byte to queue; sampled together with wr.
full  output  1  FIFO holds 2**ADDR_W entries; registered.
empty  output  1  FIFO holds 0 entries; registered.
busy  output  1  a frame is in progress (state != IDLE).
done  output  1  one-clk pulse at the end of each stop bit.
out  output  1  serial line; idles high.

Behaviour:
- Reset (asynchronous): out=1, full=0, empty=1, busy=0, done=0, FIFO pointers and count=0, state=IDLE, divider=0. Reset mid-frame aborts the frame at once and discards all queued bytes.
- FIFO: count width is ADDR_W+1; pointers wrap modulo depth.
  - Write when wr and !full.
  - Pop when the FSM loads a byte.
  - Simultaneous write and pop leaves count unchanged. This is legal when full=1: the write is rejected because full is evaluated before the edge.
  - wr while full: silently dropped, no state change.
- FSM states: IDLE, START, DATA, STOP.
  - bitcnt: 3 bits. div: counts 0..DIV-1; bit_end = (div==DIV-1).
  - IDLE: out=1. If !empty: pop into shreg, div=0, go to START.
  - START: out=0. On bit_end go to DATA with bitcnt=0.
  - DATA: out=shreg[0], LSB first. On bit_end shift right and increment bitcnt; after bitcnt=7 go to STOP.
  - STOP: out=1. On bit_end assert done for 1 clk. If !empty, pop and go to START (no gap); else go to IDLE.
- out is registered. It falls 1 clk after the edge at which a byte is written into an empty FIFO while IDLE.
- Frame length is exactly 10*DIV clks.
- busy=0 only in IDLE.
- done asserts at the same edge the line enters the next state.

Optional Feature:
UART_TX_PARITY_EN
- Defined: a PARITY state is inserted between DATA and STOP. It drives even parity (XOR of the 8 data bits) for DIV clks. Frame length is 11*DIV.
- Undefined: no PARITY state exists. Frame is 8N1 with length 10*DIV.

Test Plan:
- Reset, then idle 20 clks -> out=1, empty=1, full=0, busy=0, done never pulses.
- DIV=8, write 0xA9 while IDLE -> out holds each of 0,1,0,0,1,0,1,0,1,1 for 8 clks each, starting 1 clk after the write. done pulses once 80 clks after the start edge.
- Loopback through uart_rx_filter and uart_rx (all on clk), writing bytes 0xA9, 0x99, 0xB1, 0xEA -> uart_rx ready pulses 4 times with out matching each byte in order, and frames are contiguous with no idle gap.
- ADDR_W=2, wr high for 6 consecutive clks with din=0x01..0x06 -> full asserts after the 5th write (first byte already popped), 0x06 is dropped, exactly 5 frames are sent, and empty returns to 1.
- Assert reset during DATA bit 3 of 0x55 with 2 bytes queued -> out=1 immediately, busy=0, empty=1, no done pulse, and the line stays idle afterwards.
- With UART_TX_PARITY_EN defined, send 0x07 -> parity bit=1 and the frame lasts 88 clks; send 0xA9 -> parity bit=0.
